// File: rtl/valid_ack_fifo_bridge.sv
// Valid/ack to valid/ack bridge with a DEPTH-entry FIFO, a fill-level counter
// and a sticky consumer-ack timeout flag. Single clock domain.
module valid_ack_fifo_bridge #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ack,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ack,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         timeout_err,
    input  logic                         clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_HIT  = CW'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

    localparam logic       RX_IDLE = 1'b0;
    localparam logic       RX_ACK  = 1'b1;
    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_WAIT = 2'd1;
    localparam logic [1:0] TX_REL  = 2'd2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic              r_rx_state;
    logic [1:0]        r_tx_state;
    logic              r_in_ack;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CW-1:0]     r_cnt;
    logic              r_err;

    logic w_push;
    logic w_pop;
    logic w_load;
    logic w_to_set;

    // Acceptance looks only at the registered level, so a slot freed by a pop
    // becomes usable on the following edge.
    assign w_push   = (r_rx_state == RX_IDLE) && in_valid && (r_level != FULL_LVL);
    assign w_pop    = (r_tx_state == TX_WAIT) && out_ack;
    assign w_load   = (r_tx_state == TX_IDLE) && (r_level != '0);
    assign w_to_set = (TIMEOUT != 0) && (r_tx_state == TX_WAIT) && !out_ack &&
                      ((TIMEOUT == 1) || (r_cnt == CNT_HIT));

    assign in_ack      = r_in_ack;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign level       = r_level;
    assign timeout_err = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_state <= RX_IDLE;
            r_in_ack   <= 1'b0;
            r_wptr     <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_push) begin
                        r_in_ack   <= 1'b1;
                        r_wptr     <= r_wptr + PW'(1);
                        r_rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!in_valid) begin
                        r_in_ack   <= 1'b0;
                        r_rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_in_ack   <= 1'b0;
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // The presented word stays counted in level until the consumer acks it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_state  <= TX_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_load) begin
                        r_out_data  <= r_mem[r_rptr];
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_tx_state  <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (out_ack) begin
                        r_out_valid <= 1'b0;
                        r_rptr      <= r_rptr + PW'(1);
                        r_tx_state  <= TX_REL;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TX_REL: begin
                    if (!out_ack) begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_tx_state  <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A set on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_to_set) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

endmodule
